gray_counter_src: RTL



---
 rtl/gray_counter_src.sv | 55 +++++
 1 files changed

// File: rtl/gray_counter_src.sv
// gray_counter_src: paced up/down Gray-code generator with preload and wrap pulse; optional parity port under GRAY_PARITY_EN
//   params: WIDTH (code width, >=2), INIT_BIN (binary reset value)
//   in : clk, rst (sync, active-high), en, up_dn, load, load_bin[WIDTH], out_ready
//   out: gray_code[WIDTH], out_valid, wrap, parity (only with GRAY_PARITY_EN)
module gray_counter_src #(
  parameter int WIDTH    = 4,
  parameter int INIT_BIN = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gray_code,
  output logic             out_valid,
`ifdef GRAY_PARITY_EN
  output logic             parity,
`endif
  output logic             wrap
);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT_BIN);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic wrap_d;
  assign out_valid = state_q == RUN;
  always_comb begin
    state_d = RUN;
    bin_d   = bin_q;
    wrap_d  = 1'b0;
    if (state_q == IDLE || load) bin_d = load ? load_bin : bin_q;
    else if (out_ready && en) begin
      bin_d  = up_dn ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
      wrap_d = up_dn ? &bin_q : ~|bin_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_q     <= INIT_V;
      gray_code <= INIT_V ^ (INIT_V >> 1);
      wrap      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      gray_code <= bin_d ^ (bin_d >> 1);
      wrap      <= wrap_d;
    end
  end
`ifdef GRAY_PARITY_EN
  always_ff @(posedge clk) parity <= rst ? INIT_V[0] : bin_d[0];
`endif
endmodule
